// File: rtl/md_issue_ctrl.sv
// HI/LO issue controller: sequences multiply/divide, HI/LO writes and reads to an external unit.
// Optional MD_DIVZERO_CHK_EN aborts DIVU/DIV with a zero divisor instead of issuing it.
module md_issue_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_cmd,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        req_ready,
  input  logic        flush,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        err,
  output logic [31:0] md_d1,
  output logic [31:0] md_d2,
  output logic [1:0]  md_op,
  output logic        md_start,
  output logic        md_we,
  output logic        md_hilo,
  input  logic        md_busy,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo
);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWait,
    StWrite,
    StRead
  } state_e;

  // Value of the counter during the last WAIT cycle allowed before the abort.
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [2:0]  cmd_q;
  logic [31:0] a_q, b_q;
  logic [7:0]  cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        accept;
  logic        div_zero;

  assign req_ready = (state_q == StIdle);
  assign accept    = req_valid & req_ready & ~flush;

`ifdef MD_DIVZERO_CHK_EN
  assign div_zero = (req_cmd[2:1] == 2'b01) && (req_b == 32'd0);
`else
  assign div_zero = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (!req_cmd[2]) begin
            if (div_zero) begin
              state_d = StIdle;
              err_d   = 1'b1;
            end else begin
              state_d = StIssue;
            end
          end else if (!req_cmd[1]) begin
            state_d = StWrite;
          end else begin
            state_d = StRead;
          end
        end
      end
      StIssue: begin
        cnt_d   = 8'd0;
        state_d = flush ? StIdle : StWait;
      end
      StWait: begin
        // The unit cannot be cancelled, so flush has no effect here.
        if (!md_busy) begin
          state_d = StIdle;
        end else if (cnt_q == TimeoutLast) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StWrite: state_d = StIdle;
      StRead:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 8'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q <= 3'd0;
      a_q   <= 32'd0;
      b_q   <= 32'd0;
    end else if (accept) begin
      cmd_q <= req_cmd;
      a_q   <= req_a;
      b_q   <= req_b;
    end
  end

  assign md_d1    = a_q;
  assign md_d2    = b_q;
  assign md_op    = cmd_q[1:0];
  assign md_start = (state_q == StIssue) & ~flush;
  assign md_we    = (state_q == StWrite) & ~flush;
  assign md_hilo  = (state_q == StWrite) & cmd_q[0];
  assign rd_valid = (state_q == StRead) & ~flush;
  assign rd_data  = rd_valid ? (cmd_q[0] ? md_hi : md_lo) : 32'd0;
  assign err      = err_q;

endmodule

// File: doc/md_issue_ctrl.md
MD_ISSUE_CTRL -- requirements
Module: md_issue_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT, default 15: maximum WAIT cycles before abort, legal range 6..255.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port req_valid, input, 1 bit: the decode stage presents a HI/LO request.
REQ-005 SHALL have port req_cmd, input, 3 bits: 0 MULTU, 1 MULT, 2 DIVU, 3 DIV, 4 MTLO, 5 MTHI, 6 MFLO, 7 MFHI.
REQ-006 SHALL have ports req_a and req_b, input, 32 bits each: rs and rt operands.
REQ-007 SHALL have port req_ready, output, 1 bit: high only in IDLE.
REQ-008 SHALL have port flush, input, 1 bit: the pipeline kills the in-flight request.
REQ-009 SHALL have port rd_valid, output, 1 bit: rd_data is valid this cycle.
REQ-010 SHALL have port rd_data, output, 32 bits: MFHI/MFLO result.
REQ-011 SHALL have port err, output, 1 bit: one-cycle abort pulse.
REQ-012 SHALL have ports md_d1 and md_d2, output, 32 bits each: operands to the multiply/divide unit.
REQ-013 SHALL have ports md_op (output, 2 bits), md_start (output, 1 bit), md_we (output, 1 bit) and md_hilo (output, 1 bit): the unit's control inputs.
REQ-014 SHALL have ports md_busy (input, 1 bit), md_hi (input, 32 bits) and md_lo (input, 32 bits): the unit's status and results.

Function
REQ-015 SHALL implement the states IDLE, ISSUE, WAIT, WRITE and READ.
REQ-016 SHALL accept a request only when req_valid=1, req_ready=1 and flush=0.
- On acceptance, cmd/a/b are latched into registers.
- Next state: cmd 0-3 -> ISSUE; cmd 4-5 -> WRITE; cmd 6-7 -> READ.
REQ-017 SHALL drive md_d1 and md_d2 from the latched a and b at all times, and md_op from latched cmd[1:0].
- md_op[0] = signed.
- md_op[1] = divide.
REQ-018 SHALL, in ISSUE, hold md_start=1 for exactly one cycle, then go to WAIT.
REQ-019 SHALL stay in WAIT while md_busy=1 and go to IDLE in the cycle after the first cycle that samples md_busy=0.
- md_busy rises the cycle after start, so the first WAIT cycle always samples 1 for a correctly connected unit.
REQ-020 SHALL count WAIT cycles with an 8-bit counter.
- When the counter reaches TIMEOUT with md_busy still 1: pulse err, go to IDLE.
- The counter clears on WAIT entry.
REQ-021 SHALL, in WRITE, hold md_we=1 and md_hilo=cmd[0] for one cycle, then go to IDLE.
- MTHI writes hi, MTLO writes lo.
REQ-022 SHALL, in READ, assert rd_valid=1 for one cycle, with rd_data = md_hi if cmd[0]=1, else md_lo; then go to IDLE.
REQ-023 SHALL hold rd_data at 0 whenever rd_valid=0.
REQ-024 SHALL apply flush as follows:
- ISSUE: suppresses md_start.
- WRITE: suppresses md_we.
- READ: suppresses rd_valid.
- In each of these three states, the next state is IDLE.
- WAIT: ignored, since the unit cannot be cancelled.
REQ-025 SHALL treat flush and an abort in the same cycle as an abort (err still pulses).
REQ-026 SHALL never assert md_start and md_we in the same cycle.

Reset
REQ-027 SHALL, while reset=1, asynchronously force:
- state IDLE and WAIT counter 0;
- latched cmd/a/b to 0;
- md_start, md_we, md_hilo, md_op, md_d1, md_d2, rd_valid, rd_data and err to 0.
REQ-028 SHALL accept no request while reset=1, although req_ready reads 1 because the state is IDLE.
REQ-029 SHALL, on reset mid-operation (any state), return to IDLE with no further md_start, md_we or rd_valid pulses.

Configuration
REQ-030 SHALL, with MD_DIVZERO_CHK_EN defined, treat an accepted DIVU/DIV with req_b=0 as an abort:
- go to IDLE instead of ISSUE;
- pulse err for one cycle;
- no md_start, so HI/LO are unchanged.
REQ-031 SHALL, with MD_DIVZERO_CHK_EN undefined, issue a zero divisor normally.
- No err pulse.
- HI/LO contents are those produced by the unit.

Verification
REQ-032 SHALL cover MULT timing: MULT a=7, b=0xFFFFFFFD accepted at edge 0 -> md_start high in cycle 1; req_ready low until md_busy falls, then high again; a following MFLO then MFHI return 0xFFFFFFEB and 0xFFFFFFFF.
REQ-033 SHALL cover DIV: DIV a=0xFFFFFFF9 (-7), b=2 -> MFLO returns 0xFFFFFFFD; MFHI returns 0xFFFFFFFF; WAIT lasts as long as md_busy stays high (10 cycles with the standard unit).
REQ-034 SHALL cover MTHI: MTHI a=0x12345678 -> md_we=1 and md_hilo=1 for exactly one cycle; a following MFHI returns 0x12345678.
REQ-035 SHALL cover flush: flush in ISSUE -> no md_start and req_ready high in the next cycle; flush in WAIT -> ignored, md_busy still awaited.
REQ-036 SHALL cover timeout: model md_busy stuck high -> err pulses after TIMEOUT (15) WAIT cycles, then the FSM is in IDLE.
REQ-037 SHALL cover reset and divide-by-zero: reset asserted mid-WAIT -> all outputs 0 immediately; DIVU with b=0 under MD_DIVZERO_CHK_EN -> err pulse, no md_start, HI/LO unchanged.
